// File: rtl/credit_returner.sv
// Far-end buffer of a credit-gated stream: FWFT FIFO that returns one credit per
// beat forwarded downstream and flags beats that arrive while the FIFO is full.
module credit_returner #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_ELEMENTS = 4,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0]   in_data,
  input  logic [NUM_ELEMENTS-1:0]              in_keep,
  input  logic                                 in_last,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0]   out_data,
  output logic [NUM_ELEMENTS-1:0]              out_keep,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 credit_return,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy,
  output logic                                 overflow
);

  localparam int unsigned DataW = DATA_WIDTH * NUM_ELEMENTS;
  localparam int unsigned EntW  = DataW + NUM_ELEMENTS + 1;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned OccW  = $clog2(DEPTH + 1);

  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            credit_q, credit_d;
  logic            overflow_q, overflow_d;

  logic full, empty, push, pop;
  logic [EntW-1:0] head;

  always_comb begin
    full  = (occ_q == OccW'(DEPTH));
    empty = (occ_q == '0);
    push  = in_valid && !full;
    pop   = !empty && out_ready;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    occ_d      = occ_q + OccW'(push) - OccW'(pop);
    credit_d   = pop;
    overflow_d = overflow_q || (in_valid && full);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: contents are only visible through occupancy.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= {in_data, in_keep, in_last};
    end
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    in_ready      = !full;
    out_valid     = !empty;
    out_data      = head[EntW-1 -: DataW];
    out_keep      = head[NUM_ELEMENTS:1];
    out_last      = head[0];
    credit_return = credit_q;
    occupancy     = occ_q;
    overflow      = overflow_q;
  end

  handshake_known_a : assert property (@(posedge clk) rst_n |-> !$isunknown({in_valid, out_ready}))
    else $fatal(1, "credit_returner: unknown in_valid/out_ready");

endmodule

// File: tb/tb_credit_returner.sv
// Directed bench for credit_returner: reset, single beat, fill/overflow,
// streaming with wrap, credit loop against a gate model, reset while holding beats.
module tb_credit_returner;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_keep = '0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_keep;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         credit_return;
  logic [3:0]   occupancy;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  credit_returner #(
    .DATA_WIDTH  (32),
    .NUM_ELEMENTS(4),
    .DEPTH       (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_keep      (in_keep),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .credit_return(credit_return),
    .occupancy    (occupancy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // All DUT outputs are register-driven, so sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int credits;
  int gate_cred;
  int in_cnt;
  int out_cnt;
  int order_err;
  int max_occ;
  int cycles;
  logic will_push;
  logic will_pop;

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_out_valid", 128'(out_valid), 128'(0));
      chk("idle_credit", 128'(credit_return), 128'(0));
      chk("idle_occ", 128'(occupancy), 128'(0));
      chk("idle_in_ready", 128'(in_ready), 128'(1));
    end
    chk("idle_overflow", 128'(overflow), 128'(0));

    // Single beat
    out_ready = 1'b1;
    in_data   = 128'hA5;
    in_keep   = 4'b1111;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '0;
    in_last  = 1'b0;
    chk("single_out_valid", 128'(out_valid), 128'(1));
    chk("single_data", out_data, 128'hA5);
    chk("single_keep", 128'(out_keep), 128'hF);
    chk("single_last", 128'(out_last), 128'(1));
    chk("single_occ1", 128'(occupancy), 128'(1));
    chk("single_credit_c1", 128'(credit_return), 128'(0));
    cyc();
    chk("single_credit_c2", 128'(credit_return), 128'(1));
    chk("single_occ0", 128'(occupancy), 128'(0));
    chk("single_empty", 128'(out_valid), 128'(0));
    cyc();
    chk("single_credit_c3", 128'(credit_return), 128'(0));

    // Fill to DEPTH with out_ready low, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(32'h100 + i);
      in_keep  = 4'(i);
      in_last  = i[0];
      cyc();
    end
    chk("full_occ", 128'(occupancy), 128'(8));
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_no_ovf_yet", 128'(overflow), 128'(0));
    in_data = 128'hDEAD;
    cyc();
    in_valid = 1'b0;
    chk("ovf_set", 128'(overflow), 128'(1));
    chk("ovf_occ", 128'(occupancy), 128'(8));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 128'(out_valid), 128'(1));
      chk("drain_data", out_data, 128'(32'h100 + i));
      chk("drain_keep", 128'(out_keep), 128'(i[3:0]));
      chk("drain_last", 128'(out_last), 128'(i[0]));
      cyc();
      chk("drain_credit", 128'(credit_return), 128'(1));
    end
    chk("drain_occ", 128'(occupancy), 128'(0));
    chk("drain_empty", 128'(out_valid), 128'(0));
    cyc();
    chk("drain_credit_end", 128'(credit_return), 128'(0));
    chk("ovf_sticky", 128'(overflow), 128'(1));

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("ovf_cleared", 128'(overflow), 128'(0));

    // Streaming 100 beats, push and pop every cycle
    credits   = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(i);
      in_keep  = 4'(i);
      in_last  = i[0];
      cyc();
      if (credit_return) credits++;
      chk("stream_occ", 128'(occupancy), 128'(1));
      chk("stream_data", out_data, 128'(i));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (credit_return) credits++;
    end
    chk("stream_credits", 128'(credits), 128'(100));
    chk("stream_occ_end", 128'(occupancy), 128'(0));
    chk("stream_ovf", 128'(overflow), 128'(0));

    // Credit loop with gate model, MAX_IN_TRANSIT = 4
    gate_cred = 4;
    credits   = 0;
    in_cnt    = 0;
    out_cnt   = 0;
    order_err = 0;
    max_occ   = 0;
    cycles    = 0;
    while ((out_cnt < 1000 || credits < 1000) && cycles < 20000) begin
      in_valid  = (gate_cred > 0) && (in_cnt < 1000);
      in_data   = 128'(in_cnt);
      in_keep   = 4'(in_cnt);
      in_last   = in_cnt[0];
      out_ready = 1'($urandom_range(0, 1));
      will_push = in_valid && in_ready;
      will_pop  = out_valid && out_ready;
      if (will_pop && out_data !== 128'(out_cnt)) order_err++;
      if (will_pop) out_cnt++;
      if (will_push) begin
        in_cnt++;
        gate_cred--;
      end
      cyc();
      cycles++;
      if (credit_return) begin
        credits++;
        gate_cred++;
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("loop_in_count", 128'(in_cnt), 128'(1000));
    chk("loop_out_count", 128'(out_cnt), 128'(1000));
    chk("loop_credits", 128'(credits), 128'(1000));
    chk("loop_order", 128'(order_err), 128'(0));
    chk("loop_max_occ_le4", 128'(max_occ <= 4), 128'(1));
    chk("loop_ovf", 128'(overflow), 128'(0));

    // Reset while 5 beats are stored
    cyc();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(32'h500 + i);
      cyc();
    end
    in_valid = 1'b0;
    chk("rst5_occ_before", 128'(occupancy), 128'(5));
    rst_n = 1'b0;
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("rst5_occ", 128'(occupancy), 128'(0));
    chk("rst5_out_valid", 128'(out_valid), 128'(0));
    chk("rst5_credit", 128'(credit_return), 128'(0));
    credits = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (credit_return) credits++;
    end
    chk("rst5_no_credits", 128'(credits), 128'(0));
    chk("rst5_in_ready", 128'(in_ready), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
